// File: rtl/spi_wb_bridge.sv
// Wishbone classic slave that maps each bus access onto one SPI mode-0 frame
// to an external serial SRAM (READ 0x03 / WRITE 0x02, 24-bit address).
module spi_wb_bridge (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [23:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        spi_sck_o,
  output logic        spi_cs_n_o,
  output logic        spi_mosi_o,
  input  logic        spi_miso_i
);

  localparam int unsigned FRAME_W = 64;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned CNT_W   = 5;
  localparam logic [7:0]  CMD_READ  = 8'h03;
  localparam logic [7:0]  CMD_WRITE = 8'h02;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, ACK} state_t;

  state_t              state;
  logic [FRAME_W-1:0]  tx_sr;
  logic [WORD_W-1:0]   rx_sr;
  logic [CNT_W-1:0]    bit_cnt;
  logic [1:0]          nbytes_m1;
  logic                we_q;

  logic                accept_c;
  logic [1:0]          first_c;
  logic [1:0]          last_c;
  logic [WORD_W-1:0]   shifted_c;
  logic [FRAME_W-1:0]  frame_c;
  logic [WORD_W-1:0]   rx_next_c;
  logic                unused_adr_bits;

  assign unused_adr_bits = ^wb_adr_i[1:0];

  function automatic logic [WORD_W-1:0] byte_swap(input logic [WORD_W-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Decode the bus request into the full outgoing frame (cmd, addr, data bytes).
  always_comb begin
    first_c = 2'd0;
    last_c  = 2'd0;
    for (int i = 3; i >= 0; i--) if (wb_sel_i[i]) first_c = 2'(i);
    for (int i = 0; i < 4; i++)  if (wb_sel_i[i]) last_c  = 2'(i);
    shifted_c = wb_we_i ? (wb_dat_i >> {first_c, 3'b000}) : '0;
    frame_c   = {(wb_we_i ? CMD_WRITE : CMD_READ),
                 wb_adr_i[23:2], (wb_we_i ? first_c : 2'b00),
                 shifted_c[7:0], shifted_c[15:8], shifted_c[23:16], shifted_c[31:24]};
    // A pending ack means the master has not yet seen completion; do not re-accept.
    accept_c  = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    rx_next_c = {rx_sr[WORD_W-2:0], spi_miso_i};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      tx_sr      <= '0;
      rx_sr      <= '0;
      bit_cnt    <= '0;
      nbytes_m1  <= '0;
      we_q       <= 1'b0;
      wb_dat_o   <= '0;
      wb_ack_o   <= 1'b0;
      spi_sck_o  <= 1'b0;
      spi_cs_n_o <= 1'b1;
      spi_mosi_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wb_ack_o <= 1'b0;
          if (accept_c) begin
            if (wb_we_i && (wb_sel_i == 4'b0000)) begin
              wb_ack_o <= 1'b1;
            end else begin
              state      <= CMD;
              we_q       <= wb_we_i;
              nbytes_m1  <= wb_we_i ? 2'(last_c - first_c) : 2'd3;
              tx_sr      <= {frame_c[FRAME_W-2:0], 1'b0};
              spi_mosi_o <= frame_c[FRAME_W-1];
              spi_cs_n_o <= 1'b0;
              spi_sck_o  <= 1'b0;
              bit_cnt    <= CNT_W'(7);
            end
          end
        end
        CMD, ADDR, DATA: begin
          if (!spi_sck_o) begin
            spi_sck_o <= 1'b1;
          end else begin
            // End of a high phase: sample MISO, advance to the next bit.
            spi_sck_o  <= 1'b0;
            spi_mosi_o <= tx_sr[FRAME_W-1];
            tx_sr      <= tx_sr << 1;
            bit_cnt    <= bit_cnt - CNT_W'(1);
            if (state == DATA) rx_sr <= rx_next_c;
            if (bit_cnt == '0) begin
              case (state)
                CMD: begin
                  state   <= ADDR;
                  bit_cnt <= CNT_W'(23);
                end
                ADDR: begin
                  state   <= DATA;
                  bit_cnt <= {nbytes_m1, 3'b111};
                end
                default: begin
                  state      <= ACK;
                  spi_cs_n_o <= 1'b1;
                  spi_mosi_o <= 1'b0;
                  wb_ack_o   <= wb_cyc_i;
                  if (!we_q) wb_dat_o <= byte_swap(rx_next_c);
                end
              endcase
            end
          end
        end
        ACK: begin
          wb_ack_o <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_wb_bridge.sv
// Directed bench for spi_wb_bridge with a behavioural serial-SRAM model.
module tb_spi_wb_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_we_i = 1'b0;
  logic [23:0] wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [3:0]  wb_sel_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        spi_sck_o;
  logic        spi_cs_n_o;
  logic        spi_mosi_o;
  logic        spi_miso_i = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc_cnt  = 0;

  spi_wb_bridge dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb_cyc_i   (wb_cyc_i),
    .wb_stb_i   (wb_stb_i),
    .wb_we_i    (wb_we_i),
    .wb_adr_i   (wb_adr_i),
    .wb_dat_i   (wb_dat_i),
    .wb_sel_i   (wb_sel_i),
    .wb_dat_o   (wb_dat_o),
    .wb_ack_o   (wb_ack_o),
    .spi_sck_o  (spi_sck_o),
    .spi_cs_n_o (spi_cs_n_o),
    .spi_mosi_o (spi_mosi_o),
    .spi_miso_i (spi_miso_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Serial SRAM model, observing the link once per clk on the falling edge.
  logic [7:0]  mem [0:1023];
  logic [7:0]  mosi_q [$];
  logic [7:0]  sh;
  logic [7:0]  cmd;
  logic [23:0] addr;
  logic [7:0]  mbyte;
  int bit_k = 0, frames = 0, hi_run = 0, last_gap = 0, proto_err = 0;
  bit in_frame = 1'b0;

  always @(negedge clk) begin
    if (spi_cs_n_o !== 1'b0) begin
      in_frame   = 1'b0;
      hi_run     = hi_run + 1;
      spi_miso_i = 1'b0;
      if (spi_mosi_o === 1'b1 || spi_sck_o === 1'b1) proto_err = proto_err + 1;
    end else begin
      if (!in_frame) begin
        in_frame = 1'b1;
        frames   = frames + 1;
        last_gap = hi_run;
        hi_run   = 0;
        bit_k    = 0;
        cmd      = 8'h00;
        sh       = 8'h00;
        mosi_q.delete();
      end
      if (spi_sck_o === 1'b0) begin
        if (bit_k >= 32 && cmd == 8'h03) begin
          mbyte      = mem[(int'(addr) + (bit_k - 32) / 8) % 1024];
          spi_miso_i = mbyte[3'(7 - (bit_k % 8))];
        end else begin
          spi_miso_i = 1'b0;
        end
      end else begin
        sh = {sh[6:0], spi_mosi_o};
        if (bit_k % 8 == 7) begin
          mosi_q.push_back(sh);
          case (bit_k / 8)
            0: cmd = sh;
            1: addr[23:16] = sh;
            2: addr[15:8]  = sh;
            3: addr[7:0]   = sh;
            default: if (cmd == 8'h02) mem[(int'(addr) + bit_k / 8 - 4) % 1024] = sh;
          endcase
        end
        bit_k = bit_k + 1;
      end
    end
  end

  // Bus transfer: called just after a rising edge, returns just after one.
  task automatic wb_xfer(input logic we, input logic [23:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output int lat, output logic [31:0] rd);
    int t0;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr;  wb_dat_i = dat;  wb_sel_i = sel;
    t0  = cyc_cnt;
    lat = -1;
    rd  = 'x;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (wb_ack_o === 1'b1) begin
        lat = cyc_cnt - t0;
        rd  = wb_dat_o;
        break;
      end
    end
    @(posedge clk); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_adr_i = 24'h000104; wb_sel_i = 4'hF;
    repeat (4) begin
      @(negedge clk);
      n_checks++;
      if ({spi_cs_n_o, spi_sck_o, spi_mosi_o, wb_ack_o} !== 4'b1000)
        $display("FAIL reset_pins: got cs/sck/mosi/ack=%b want 1000",
                 {spi_cs_n_o, spi_sck_o, spi_mosi_o, wb_ack_o});
      else n_pass++;
    end
    n_checks++;
    if (wb_dat_o !== 32'h0) $display("FAIL reset_dat: got %h want 00000000", wb_dat_o);
    else n_pass++;
    n_checks++;
    if (frames !== 0) $display("FAIL reset_no_frame: got %0d frames want 0", frames);
    else n_pass++;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_read;
    int lat; logic [31:0] rd;
    logic [7:0] exp_b [8] = '{8'h03, 8'h00, 8'h01, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
    wb_xfer(1'b0, 24'h000104, 32'h0, 4'hF, lat, rd);
    n_checks++;
    if (lat !== 129) $display("FAIL read_lat: got %0d want 129", lat); else n_pass++;
    n_checks++;
    if (rd !== 32'h44332211) $display("FAIL read_data: got %h want 44332211", rd); else n_pass++;
    n_checks++;
    if (mosi_q.size() !== 8) $display("FAIL read_len: got %0d bytes want 8", mosi_q.size());
    else begin
      n_pass++;
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (mosi_q[i] !== exp_b[i]) $display("FAIL read_mosi[%0d]: got %h want %h", i, mosi_q[i], exp_b[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_write_word;
    int lat; logic [31:0] rd;
    logic [7:0] exp_b [8] = '{8'h02, 8'h00, 8'h02, 8'h00, 8'hD4, 8'hC3, 8'hB2, 8'hA1};
    wb_xfer(1'b1, 24'h000200, 32'hA1B2C3D4, 4'b1111, lat, rd);
    n_checks++;
    if (lat !== 129) $display("FAIL wr_word_lat: got %0d want 129", lat); else n_pass++;
    n_checks++;
    if (rd !== 32'h44332211) $display("FAIL wr_word_dat_hold: got %h want 44332211", rd); else n_pass++;
    n_checks++;
    if (mosi_q.size() !== 8) $display("FAIL wr_word_len: got %0d bytes want 8", mosi_q.size());
    else begin
      n_pass++;
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (mosi_q[i] !== exp_b[i]) $display("FAIL wr_word_mosi[%0d]: got %h want %h", i, mosi_q[i], exp_b[i]);
        else n_pass++;
      end
    end
    wb_xfer(1'b0, 24'h000200, 32'h0, 4'hF, lat, rd);
    n_checks++;
    if (rd !== 32'hA1B2C3D4) $display("FAIL wr_word_readback: got %h want a1b2c3d4", rd); else n_pass++;
  endtask

  task automatic test_write_byte;
    int lat; logic [31:0] rd;
    logic [7:0] exp_b [5] = '{8'h02, 8'h00, 8'h03, 8'h02, 8'hEE};
    logic [7:0] exp_m [4] = '{8'h55, 8'h66, 8'hEE, 8'h88};
    mem[10'h300] = 8'h55; mem[10'h301] = 8'h66; mem[10'h302] = 8'h77; mem[10'h303] = 8'h88;
    wb_xfer(1'b1, 24'h000300, 32'h00EE0000, 4'b0100, lat, rd);
    n_checks++;
    if (lat !== 81) $display("FAIL wr_byte_lat: got %0d want 81", lat); else n_pass++;
    n_checks++;
    if (rd !== 32'hA1B2C3D4) $display("FAIL wr_byte_dat_hold: got %h want a1b2c3d4", rd); else n_pass++;
    n_checks++;
    if (mosi_q.size() !== 5) $display("FAIL wr_byte_len: got %0d bytes want 5", mosi_q.size());
    else begin
      n_pass++;
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (mosi_q[i] !== exp_b[i]) $display("FAIL wr_byte_mosi[%0d]: got %h want %h", i, mosi_q[i], exp_b[i]);
        else n_pass++;
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (mem[10'h300 + i] !== exp_m[i]) $display("FAIL wr_byte_mem[%0d]: got %h want %h", i, mem[10'h300 + i], exp_m[i]);
      else n_pass++;
    end
    wb_xfer(1'b0, 24'h000300, 32'h0, 4'hF, lat, rd);
    n_checks++;
    if (rd !== 32'h88EE6655) $display("FAIL wr_byte_readback: got %h want 88ee6655", rd); else n_pass++;
  endtask

  task automatic test_write_nosel;
    int lat, f0; logic [31:0] rd;
    f0 = frames;
    wb_xfer(1'b1, 24'h000200, 32'hFFFFFFFF, 4'b0000, lat, rd);
    n_checks++;
    if (lat !== 1) $display("FAIL nosel_lat: got %0d want 1", lat); else n_pass++;
    n_checks++;
    if (frames !== f0) $display("FAIL nosel_no_frame: got %0d frames want %0d", frames, f0); else n_pass++;
    n_checks++;
    if (rd !== 32'h88EE6655) $display("FAIL nosel_dat_hold: got %h want 88ee6655", rd); else n_pass++;
    n_checks++;
    if (mem[10'h200] !== 8'hD4) $display("FAIL nosel_mem: got %h want d4", mem[10'h200]); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int lat1, lat2; logic [31:0] rd1, rd2;
    wb_xfer(1'b0, 24'h000104, 32'h0, 4'hF, lat1, rd1);
    wb_xfer(1'b0, 24'h000200, 32'h0, 4'hF, lat2, rd2);
    n_checks++;
    if (rd1 !== 32'h44332211) $display("FAIL b2b_rd1: got %h want 44332211", rd1); else n_pass++;
    n_checks++;
    if (rd2 !== 32'hA1B2C3D4 || lat2 !== 129)
      $display("FAIL b2b_rd2: got %h lat %0d want a1b2c3d4 lat 129", rd2, lat2);
    else n_pass++;
    n_checks++;
    if (last_gap !== 2) $display("FAIL b2b_cs_gap: got %0d cycles want 2", last_gap); else n_pass++;
  endtask

  task automatic test_reset_mid_frame;
    int lat; logic [31:0] rd; bit ack_seen, cs_seen;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
    wb_adr_i = 24'h000200; wb_sel_i = 4'hF;
    repeat (40) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (spi_cs_n_o !== 1'b0) $display("FAIL rst_mid_cs_before: got %b want 0", spi_cs_n_o); else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({spi_cs_n_o, spi_sck_o, spi_mosi_o, wb_ack_o} !== 4'b1000)
      $display("FAIL rst_mid_pins: got cs/sck/mosi/ack=%b want 1000",
               {spi_cs_n_o, spi_sck_o, spi_mosi_o, wb_ack_o});
    else n_pass++;
    n_checks++;
    if (wb_dat_o !== 32'h0) $display("FAIL rst_mid_dat: got %h want 00000000", wb_dat_o); else n_pass++;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    ack_seen = 1'b0; cs_seen = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (wb_ack_o === 1'b1) ack_seen = 1'b1;
      if (spi_cs_n_o !== 1'b1) cs_seen = 1'b1;
    end
    n_checks++;
    if (ack_seen || cs_seen) $display("FAIL rst_mid_quiet: got ack=%b cs_low=%b want 0 0", ack_seen, cs_seen);
    else n_pass++;
    @(posedge clk); #1;
    wb_xfer(1'b0, 24'h000104, 32'h0, 4'b0001, lat, rd);
    n_checks++;
    if (rd !== 32'h44332211 || lat !== 129)
      $display("FAIL rst_mid_recover: got %h lat %0d want 44332211 lat 129", rd, lat);
    else n_pass++;
  endtask

  task automatic test_cyc_drop;
    int t0, j; bit ack_seen; logic cs128, cs129;
    logic [7:0] exp_b [4] = '{8'h03, 8'h00, 8'h02, 8'h00};
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
    wb_adr_i = 24'h000200; wb_sel_i = 4'hF;
    t0 = cyc_cnt;
    repeat (10) @(posedge clk);
    #1 wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    ack_seen = 1'b0; cs128 = 1'bx; cs129 = 1'bx;
    repeat (150) begin
      @(negedge clk);
      j = cyc_cnt - t0;
      if (wb_ack_o === 1'b1) ack_seen = 1'b1;
      if (j == 128) cs128 = spi_cs_n_o;
      if (j == 129) cs129 = spi_cs_n_o;
    end
    n_checks++;
    if (ack_seen) $display("FAIL drop_no_ack: got ack=1 want 0"); else n_pass++;
    n_checks++;
    if ({cs128, cs129} !== 2'b01) $display("FAIL drop_frame_len: got cs@128/129=%b want 01", {cs128, cs129});
    else n_pass++;
    n_checks++;
    if (mosi_q.size() !== 8) $display("FAIL drop_len: got %0d bytes want 8", mosi_q.size());
    else begin
      n_pass++;
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (mosi_q[i] !== exp_b[i]) $display("FAIL drop_mosi[%0d]: got %h want %h", i, mosi_q[i], exp_b[i]);
        else n_pass++;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[10'h104] = 8'h11; mem[10'h105] = 8'h22; mem[10'h106] = 8'h33; mem[10'h107] = 8'h44;
    test_reset();
    test_read();
    test_write_word();
    test_write_byte();
    test_write_nosel();
    test_back_to_back();
    test_reset_mid_frame();
    test_cyc_drop();
    n_checks++;
    if (proto_err !== 0) $display("FAIL idle_pins: got %0d cycles with sck/mosi high while cs_n high want 0", proto_err);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/spi_wb_bridge.md
SPI_WB_BRIDGE -- requirements
Module: spi_wb_bridge

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset: clk input 1 (rising-edge, all state); rst_n input 1 (sampled on clk, low = reset).
REQ-002 wb_cyc_i, wb_stb_i, wb_we_i  input 1 each; Wishbone classic bus cycle/strobe/write from the SERV core.
REQ-003 wb_adr_i  input 24  byte address; bits [1:0] ignored (word-aligned).
REQ-004 wb_dat_i  input 32  write data, little-endian; wb_sel_i  input 4  byte enables.
REQ-005 wb_dat_o  output 32  read data; wb_ack_o  output 1  single-cycle acknowledge.
REQ-006 spi_sck_o, spi_cs_n_o, spi_mosi_o  output 1 each; spi_miso_i  input 1; SPI mode 0 link to external serial SRAM (READ 0x03 / WRITE 0x02, 24-bit address).

Function
REQ-007 FSM states SHALL be IDLE, CMD, ADDR, DATA, ACK; transitions IDLE->CMD->ADDR->DATA->ACK->IDLE only.
REQ-008 Request accepted in IDLE when wb_cyc_i & wb_stb_i (cycle T); accepted-cycle adr/dat/sel/we SHALL be registered, later bus changes ignored.
REQ-009 Read: cmd 0x03, address {adr[23:2],2'b00}, 4 data bytes regardless of wb_sel_i.
REQ-010 Write: cmd 0x02, address {adr[23:2],f} with f = index of lowest set sel bit, then bytes f..h (h = highest set bit) in ascending order; sel is contiguous by bus contract.
REQ-011 Write with wb_sel_i = 0: no SPI activity, wb_ack_o high at T+1, back to IDLE.
REQ-012 Bit timing: frame of B = 32 + 8N bits (N data bytes); bit k occupies cycles T+1+2k (sck=0, MOSI updated) and T+2+2k (sck=1); all fields MSB-first.
REQ-013 spi_cs_n_o SHALL be 0 from T+1 through T+2B inclusive, 1 otherwise.
REQ-014 MISO SHALL be sampled on the clk edge ending each sck=1 cycle; read byte i (i-th received) lands in wb_dat_o[8i+7:8i].
REQ-015 ACK at cycle T+1+2B: cs_n=1, sck=0, wb_ack_o=1 for exactly one cycle; read ack at T+129, full-word write ack at T+129, single-byte write ack at T+81.
REQ-016 IDLE at T+2+2B; earliest next accept T+2+2B, guaranteeing >= 1 cycle cs_n high between frames.
REQ-017 wb_dat_o SHALL update only at read ACK and hold until the next read ACK; writes leave it unchanged.
REQ-018 wb_cyc_i dropped mid-frame: frame SHALL complete unchanged; wb_ack_o suppressed if wb_cyc_i is low in the ACK cycle.
REQ-019 spi_mosi_o SHALL be 0 whenever cs_n is high; spi_sck_o SHALL idle low.
REQ-020 wb_ack_o SHALL never assert in IDLE except per REQ-011.

Reset
REQ-021 rst_n low at a clk edge: next cycle state=IDLE, spi_cs_n_o=1, spi_sck_o=0, spi_mosi_o=0, wb_ack_o=0, wb_dat_o=32'h0.
REQ-022 Reset mid-frame SHALL abort: cs_n high next cycle, no ack issued, captured request discarded.
REQ-023 Requests while rst_n low SHALL be ignored; first accept possible at the first edge with rst_n high.

Verification
REQ-024 Read adr 0x000104, SRAM model holds bytes 11 22 33 44 at 0x104..0x107 -> MOSI 0x03,0x000104; ack at T+129; wb_dat_o=0x44332211.
REQ-025 Write adr 0x000200, dat 0xA1B2C3D4, sel 1111 -> MOSI 0x02,0x000200,D4,C3,B2,A1; ack at T+129; readback 0xA1B2C3D4.
REQ-026 Write adr 0x000300, dat 0x00EE0000, sel 0100 -> MOSI 0x02,0x000302,EE; ack at T+81; only byte 0x302 changed.
REQ-027 Write sel 0000 -> cs_n stays high, ack at T+1; back-to-back reads -> cs_n high >= 1 cycle between frames.
REQ-028 rst_n low at T+40 of a read -> cs_n=1 at T+41, no ack, next read completes correctly; wb_cyc_i dropped at T+10 -> frame completes, no ack.
